// File: rtl/uart_cmd_parser.sv
`timescale 1ns/1ps
// Decodes ASCII hex command lines from a UART RX byte stream into register
// write/read strobes and sends the response bytes to the UART TX.
module uart_cmd_parser #(
  parameter logic [7:0]  ACK_CHAR = 8'h4B,
  parameter logic [7:0]  ERR_CHAR = 8'h3F,
  parameter logic [23:0] TIMEOUT  = 24'd5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_wait,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_wait,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_HEX      = 3'd1;
  localparam logic [2:0] S_ERR      = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_RD       = 3'd4;
  localparam logic [2:0] S_RESP_ERR = 3'd5;
  localparam logic [2:0] S_RESP     = 3'd6;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  // Returns {valid, nibble}; letters map via low nibble + 9 for both cases.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [4:0] r;
    r = 5'd0;
    if (b >= 8'h30 && b <= 8'h39)
      r = {1'b1, b[3:0]};
    else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
      r = {1'b1, b[3:0] + 4'd9};
    return r;
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  logic [2:0]  state;
  logic [15:0] acc;
  logic [2:0]  nib_cnt;
  logic        is_write;
  logic [23:0] tmo_cnt;
  logic [23:0] resp_buf;
  logic [1:0]  resp_rem;

  logic        accept;
  logic        is_eol;
  logic [4:0]  dec;
  logic [2:0]  need;
  logic        tmo_hit;

  // rx_wait comes only from the registered state, so each byte lands in exactly one state.
  assign rx_wait = (state == S_EXEC) || (state == S_RD) ||
                   (state == S_RESP_ERR) || (state == S_RESP);
  assign accept  = rx_valid & ~rx_wait;
  assign is_eol  = (rx_data == CR) || (rx_data == LF);
  assign dec     = hex_decode(rx_data);
  assign need    = is_write ? 3'd4 : 3'd2;
  assign tmo_hit = (TIMEOUT != 24'd0) && (tmo_cnt == TIMEOUT - 24'd1);

  // Strobe address/data are registered on the EOL edge so they are valid during EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= 16'h0000;
      nib_cnt   <= 3'd0;
      is_write  <= 1'b0;
      tmo_cnt   <= 24'd0;
      resp_buf  <= 24'h000000;
      resp_rem  <= 2'd0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      case (state)
        S_IDLE: begin
          tmo_cnt <= 24'd0;
          if (accept && !is_eol) begin
            acc     <= 16'h0000;
            nib_cnt <= 3'd0;
            if (rx_data == 8'h57 || rx_data == 8'h77) begin
              is_write <= 1'b1;
              state    <= S_HEX;
            end else if (rx_data == 8'h52 || rx_data == 8'h72) begin
              is_write <= 1'b0;
              state    <= S_HEX;
            end else begin
              state <= S_ERR;
            end
          end
        end
        S_HEX: begin
          if (accept) begin
            tmo_cnt <= 24'd0;
            if (is_eol) begin
              if (nib_cnt == need) begin
                state <= S_EXEC;
                if (is_write) begin
                  reg_addr  <= acc[15:8];
                  reg_wdata <= acc[7:0];
                  reg_we    <= 1'b1;
                end else begin
                  reg_addr <= acc[7:0];
                  reg_re   <= 1'b1;
                end
              end else begin
                state <= S_RESP_ERR;
              end
            end else if (dec[4] && nib_cnt != need) begin
              acc     <= {acc[11:0], dec[3:0]};
              nib_cnt <= nib_cnt + 3'd1;
            end else begin
              state <= S_ERR;
            end
          end else if (tmo_hit) begin
            tmo_cnt <= 24'd0;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end
        S_ERR: begin
          if (accept) begin
            tmo_cnt <= 24'd0;
            if (is_eol)
              state <= S_RESP_ERR;
          end else if (tmo_hit) begin
            tmo_cnt <= 24'd0;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end
        S_EXEC: begin
          tmo_cnt <= 24'd0;
          if (is_write) begin
            tx_data  <= ACK_CHAR;
            tx_valid <= 1'b1;
            resp_buf <= {CR, LF, 8'h00};
            resp_rem <= 2'd2;
            state    <= S_RESP;
          end else begin
            state <= S_RD;
          end
        end
        S_RD: begin
          tx_data  <= hex_ascii(reg_rdata[7:4]);
          tx_valid <= 1'b1;
          resp_buf <= {hex_ascii(reg_rdata[3:0]), CR, LF};
          resp_rem <= 2'd3;
          state    <= S_RESP;
        end
        S_RESP_ERR: begin
          tx_data  <= ERR_CHAR;
          tx_valid <= 1'b1;
          resp_buf <= {CR, LF, 8'h00};
          resp_rem <= 2'd2;
          state    <= S_RESP;
        end
        S_RESP: begin
          if (tx_valid && !tx_wait) begin
            if (resp_rem == 2'd0) begin
              tx_valid <= 1'b0;
              state    <= S_IDLE;
            end else begin
              tx_data  <= resp_buf[23:16];
              resp_buf <= {resp_buf[15:0], 8'h00};
              resp_rem <= resp_rem - 2'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
`timescale 1ns/1ps
// Self-checking bench for uart_cmd_parser: fixed vector table, random lines
// against a grammar-level model, and hand-written timeout/backpressure/reset cases.
module tb_uart_cmd_parser;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [63:0] ERR_TX = 64'h3F0D0A;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_wait;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_wait;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic [7:0] rdata_value;

  int checks = 0;
  int errors = 0;

  byte unsigned tx_q[$];
  logic [15:0]  we_q[$];
  logic [7:0]   re_q[$];

  typedef struct {
    logic [63:0] text;
    int          len;
    logic [7:0]  rdata;
    int          n_we;
    logic [15:0] we_val;
    int          n_re;
    logic [7:0]  re_val;
    logic [63:0] tx;
    int          tx_len;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;
  assign reg_rdata = rdata_value;

  uart_cmd_parser #(.TIMEOUT(24'd100)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_wait(rx_wait),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_wait(tx_wait),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata)
  );

  // Observes TX transfers and strobes one half-cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && !tx_wait) tx_q.push_back(tx_data);
      if (reg_we) we_q.push_back({reg_addr, reg_wdata});
      if (reg_re) re_q.push_back(reg_addr);
      if (reg_we && reg_re) begin
        checks++;
        errors++;
        $display("[TB] FAIL strobe_overlap: reg_we=%0b reg_re=%0b, required not both", reg_we, reg_re);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_obs();
    tx_q.delete();
    we_q.delete();
    re_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (rx_wait && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (rx_wait) begin
      checks++;
      errors++;
      $display("[TB] FAIL rx_accept: byte %h not accepted, rx_wait=%0b required 0", b, rx_wait);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_text(input logic [63:0] text, input int len);
    for (int i = 0; i < len; i++)
      send_byte(text[8*(len-1-i) +: 8]);
  endtask

  task automatic applyStimulus(input logic [63:0] text, input int len);
    send_text(text, len);
    repeat (12) @(posedge clk);
  endtask

  task automatic checkOutput(input string name, input int n_we, input logic [15:0] we_val,
                             input int n_re, input logic [7:0] re_val,
                             input logic [63:0] exp_tx, input int exp_len);
    logic [63:0] act;
    act = 64'd0;
    foreach (tx_q[i]) act = {act[55:0], tx_q[i]};
    @(negedge clk);
    checks++;
    if (we_q.size() != n_we) begin
      errors++;
      $display("[TB] FAIL %s we_count: got %0d required %0d", name, we_q.size(), n_we);
    end else if (n_we > 0) begin
      checks++;
      if (we_q[0] !== we_val) begin
        errors++;
        $display("[TB] FAIL %s we_addr_data: got %h required %h", name, we_q[0], we_val);
      end
    end
    checks++;
    if (re_q.size() != n_re) begin
      errors++;
      $display("[TB] FAIL %s re_count: got %0d required %0d", name, re_q.size(), n_re);
    end else if (n_re > 0) begin
      checks++;
      if (re_q[0] !== re_val) begin
        errors++;
        $display("[TB] FAIL %s re_addr: got %h required %h", name, re_q[0], re_val);
      end
    end
    checks++;
    if (tx_q.size() != exp_len || act !== exp_tx) begin
      errors++;
      $display("[TB] FAIL %s tx_bytes: got %0d bytes %h required %0d bytes %h",
               name, tx_q.size(), act, exp_len, exp_tx);
    end
    checks++;
    if (rx_wait !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s idle_after: rx_wait=%b tx_valid=%b required 0 0", name, rx_wait, tx_valid);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({rx_wait, tx_valid, tx_data, reg_addr, reg_wdata, reg_we, reg_re} !== 28'd0) begin
      errors++;
      $display("[TB] FAIL %s reset_values: rx_wait=%b tx_valid=%b tx_data=%h addr=%h wdata=%h we=%b re=%b required all 0",
               name, rx_wait, tx_valid, tx_data, reg_addr, reg_wdata, reg_we, reg_re);
    end
  endtask

  initial begin
    string hexset;
    string hexup;
    string badset;
    string cmdset;
    logic [63:0] text;
    logic [63:0] exp_tx;
    logic [15:0] val;
    logic [7:0]  cmd;
    logic [7:0]  rd;
    int len, ndig, idx, need, exp_len, n_we, n_re;
    bit all_hex, is_w, ok, hold_ok;

    hexset = "0123456789abcdefABCDEF";
    hexup  = "0123456789ABCDEF";
    badset = "G:@g z/";
    cmdset = "WwRrX";

    vecs[0]  = '{{"W3A5C", CR}, 6, 8'h00, 1, 16'h3A5C, 0, 8'h00, 64'h4B0D0A, 3};
    vecs[1]  = '{{"r3a", LF},   4, 8'hF0, 0, 16'h0000, 1, 8'h3A, 64'h46300D0A, 4};
    vecs[2]  = '{{"W12G4", CR}, 6, 8'h00, 0, 16'h0000, 0, 8'h00, ERR_TX, 3};
    vecs[3]  = '{{"R123", CR},  5, 8'h00, 0, 16'h0000, 0, 8'h00, ERR_TX, 3};
    vecs[4]  = '{{"X", CR},     2, 8'h00, 0, 16'h0000, 0, 8'h00, ERR_TX, 3};
    vecs[5]  = '{{"W12", CR},   4, 8'h00, 0, 16'h0000, 0, 8'h00, ERR_TX, 3};
    vecs[6]  = '{{CR, LF, CR},  3, 8'h00, 0, 16'h0000, 0, 8'h00, 64'h0, 0};
    vecs[7]  = '{{"w00fF", LF}, 6, 8'h00, 1, 16'h00FF, 0, 8'h00, 64'h4B0D0A, 3};
    vecs[8]  = '{{"RfF", CR},   4, 8'h0A, 0, 16'h0000, 1, 8'hFF, 64'h30410D0A, 4};
    vecs[9]  = '{{"W12345", CR}, 7, 8'h00, 0, 16'h0000, 0, 8'h00, ERR_TX, 3};
    vecs[10] = '{{"R", CR},     2, 8'h00, 0, 16'h0000, 0, 8'h00, ERR_TX, 3};
    vecs[11] = '{{"Wab:d", CR}, 6, 8'h00, 0, 16'h0000, 0, 8'h00, ERR_TX, 3};
    vecs[12] = '{{"R@0", CR},   4, 8'h00, 0, 16'h0000, 0, 8'h00, ERR_TX, 3};
    vecs[13] = '{{"Rg0", CR},   4, 8'h00, 0, 16'h0000, 0, 8'h00, ERR_TX, 3};
    vecs[14] = '{{"R9A", CR},   4, 8'h9C, 0, 16'h0000, 1, 8'h9A, 64'h39430D0A, 4};

    rst = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    tx_wait = 1'b0;
    rdata_value = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("initial");
    #1 rst = 1'b0;

    for (int v = 0; v < 15; v++) begin
      clear_obs();
      rdata_value = vecs[v].rdata;
      applyStimulus(vecs[v].text, vecs[v].len);
      checkOutput($sformatf("vec%0d", v), vecs[v].n_we, vecs[v].we_val,
                  vecs[v].n_re, vecs[v].re_val, vecs[v].tx, vecs[v].tx_len);
    end

    // Random lines scored by the grammar rules alone.
    for (int n = 0; n < 40; n++) begin
      clear_obs();
      rd = 8'($urandom_range(0, 255));
      rdata_value = rd;
      cmd = cmdset[$urandom_range(0, 4)];
      is_w = (cmd == "W" || cmd == "w");
      need = is_w ? 4 : 2;
      ndig = $urandom_range(0, 5);
      text = {56'd0, cmd};
      len = 1;
      val = 16'd0;
      all_hex = 1'b1;
      for (int d = 0; d < ndig; d++) begin
        if ($urandom_range(0, 9) == 0) begin
          text = {text[55:0], 8'(badset[$urandom_range(0, 6)])};
          all_hex = 1'b0;
        end else begin
          idx = $urandom_range(0, 21);
          text = {text[55:0], 8'(hexset[idx])};
          val = val * 16 + ((idx < 16) ? idx : idx - 6);
        end
        len++;
      end
      text = {text[55:0], ($urandom_range(0, 1) != 0) ? CR : LF};
      len++;
      ok = (cmd != "X") && all_hex && (ndig == need);
      n_we = 0;
      n_re = 0;
      if (ok && is_w) begin
        n_we = 1;
        exp_tx = 64'h4B0D0A;
        exp_len = 3;
      end else if (ok) begin
        n_re = 1;
        exp_tx = {32'd0, 8'(hexup[rd / 16]), 8'(hexup[rd % 16]), CR, LF};
        exp_len = 4;
      end else begin
        exp_tx = ERR_TX;
        exp_len = 3;
      end
      applyStimulus(text, len);
      checkOutput($sformatf("rand%0d", n), n_we, val, n_re, val[7:0], exp_tx, exp_len);
    end

    // Idle gap just under the timeout must not abort the line.
    clear_obs();
    send_text({"W12"}, 3);
    repeat (90) @(posedge clk);
    applyStimulus({"34", CR}, 3);
    checkOutput("tmo_below", 1, 16'h1234, 0, 8'h00, 64'h4B0D0A, 3);

    // Idle gap beyond the timeout silently drops the partial line.
    clear_obs();
    rdata_value = 8'h55;
    send_text({"W12"}, 3);
    repeat (150) @(posedge clk);
    applyStimulus({"R12", CR}, 4);
    checkOutput("tmo_fire", 0, 16'h0000, 1, 8'h12, 64'h35350D0A, 4);

    // TX backpressure during the ACK with the next command already offered.
    clear_obs();
    rdata_value = 8'hC3;
    @(posedge clk);
    #1 tx_wait = 1'b1;
    applyStimulus({"W0102", CR}, 6);
    @(posedge clk);
    #1;
    rx_data  = "R";
    rx_valid = 1'b1;
    hold_ok = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (!(tx_valid === 1'b1 && tx_data === 8'h4B && rx_wait === 1'b1)) hold_ok = 1'b0;
    end
    checks++;
    if (!hold_ok || tx_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL hold_stable: tx_valid=%b tx_data=%h rx_wait=%b sent=%0d required 1 4B 1 0",
               tx_valid, tx_data, rx_wait, tx_q.size());
    end
    @(posedge clk);
    #1 tx_wait = 1'b0;
    idx = 0;
    @(negedge clk);
    while (rx_wait && idx < 50) begin
      @(negedge clk);
      idx++;
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
    applyStimulus({"01", CR}, 3);
    checkOutput("hold", 1, 16'h0102, 1, 8'h01, 64'h4B0D0A43330D0A, 7);

    // Reset mid-line clears outputs asynchronously and discards the partial line.
    clear_obs();
    send_text({"W12"}, 3);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_values("mid_line");
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus({"W0101", CR}, 6);
    checkOutput("after_reset", 1, 16'h0101, 0, 8'h00, 64'h4B0D0A, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
